data_memory_responder: RTL

- MEM-stage data memory responder with a multi-cycle access handshake.
- Accepts load/store requests from the MEM stage and returns RD, the read data that the MEM/WB register captures.
- Freezes the pipeline through StallMem while an access is in flight.
- Single clock domain; replaces the ideal zero-latency data memory so that slow-memory behaviour can be modelled.

---
 rtl/mips_mem_pkg.sv | 20 ++
 rtl/dmem_array.sv | 37 +++
 rtl/data_memory_responder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data memory: FSM states, default
// geometry/latency, and byte-address to word-index extraction.
package mips_mem_pkg;

    localparam int DEFAULT_DEPTH   = 256;
    localparam int DEFAULT_ADDR_W  = 8;
    localparam int DEFAULT_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    // Full word address; callers truncate to ADDR_W, so addresses wrap modulo DEPTH*4.
    function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port 32-bit RAM with read-before-write behaviour and a
// read-data register that only updates on an enabled read.
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: the storage array has no reset; contents survive reset and are
    // loaded through the preload port instead.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Both blocks sample mem[idx] before the write lands, giving the old word.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// MEM-stage data memory with a LATENCY-cycle access handshake; StallMem
// freezes the pipeline until the access completes and RD is valid.
module data_memory_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [31:0]       ALUOutM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       RD,
    output logic              StallMem,
    input  logic              InitEn,
    input  logic [ADDR_W-1:0] InitAddr,
    input  logic [31:0]       InitData
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("data_memory_responder: LATENCY must be at least 1");
        end
        if ((1 << ADDR_W) != DEPTH) begin : g_bad_depth
            $error("data_memory_responder: DEPTH must equal 2**ADDR_W");
        end
    endgenerate

    mem_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic              is_read_q;
    logic              is_write_q;

    logic              req;
    logic [ADDR_W-1:0] req_idx;
    logic              access;
    logic              ram_re;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_idx;
    logic [31:0]       ram_wdata;

    assign req     = MemReadM | MemWriteM;
    assign req_idx = ADDR_W'(word_addr(ALUOutM));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state      <= BUSY;
                        cnt        <= CNT_W'(LATENCY - 1);
                        idx_q      <= req_idx;
                        wdata_q    <= WriteDataM;
                        is_read_q  <= MemReadM;
                        is_write_q <= MemWriteM;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The access edge is gated by reset so an aborted store never reaches the array.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        access    = (state == BUSY) && (cnt == '0) && !reset;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_idx   = idx_q;
        ram_wdata = wdata_q;
        if (access) begin
            ram_re = is_read_q;
            ram_we = is_write_q;
        end else if ((state == IDLE) && !req && InitEn && !reset) begin
            ram_we    = 1'b1;
            ram_idx   = InitAddr;
            ram_wdata = InitData;
        end
    end

    always_comb begin
        case (state)
            IDLE:    StallMem = req;
            BUSY:    StallMem = 1'b1;
            DONE:    StallMem = 1'b0;
            default: StallMem = 1'b0;
        endcase
    end

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .re    (ram_re),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (ram_wdata),
        .rdata (RD)
    );

endmodule
